// File: rtl/minimips_instr_sequencer.sv
// MiniMIPS instruction sequencer: loadable program store, PC walker, valid/ready issue stream.
// Define MINIMIPS_RESULT_CAPTURE_EN to add the result-capture RAM behind res_*/dbg_*.
module minimips_instr_sequencer #(
  parameter int INSTR_W  = 16,
  parameter int PC_W     = 6,
  parameter int RESULT_W = 32,
  parameter int COUNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                prog_we,
  input  logic [PC_W-1:0]     prog_addr,
  input  logic [INSTR_W-1:0]  prog_data,
  input  logic                start,
  input  logic                stop,
  input  logic                loop_en,
  input  logic [PC_W-1:0]     last_addr,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [INSTR_W-1:0]  instr,
  output logic [PC_W-1:0]     instr_pc,
  output logic                busy,
  output logic                done,
  output logic                prog_err,
  output logic [COUNT_W-1:0]  issue_cnt,
  input  logic                res_valid,
  input  logic [PC_W-1:0]     res_pc,
  input  logic [RESULT_W-1:0] res_data,
  input  logic [PC_W-1:0]     dbg_addr,
  output logic [RESULT_W-1:0] dbg_data
);

  localparam int DEPTH = 1 << PC_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    last_q;
  logic               loop_q;
  logic               hs;
  logic               at_last;
  logic [PC_W-1:0]    pc_nxt;
  logic [INSTR_W-1:0] prog_mem [DEPTH];

  assign instr_valid = (state == S_ISSUE);
  assign busy        = (state == S_FETCH) || (state == S_ISSUE);
  assign hs          = instr_valid && instr_ready;
  assign at_last     = (pc == last_q);
  assign pc_nxt      = at_last ? '0 : pc + PC_W'(1);

  // Store is only writable outside a run, so issue reads never race a write.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) prog_mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      last_q    <= '0;
      loop_q    <= 1'b0;
      done      <= 1'b0;
      prog_err  <= 1'b0;
      issue_cnt <= '0;
      instr     <= '0;
      instr_pc  <= '0;
    end else begin
      prog_err <= prog_we && busy;
      if (hs && (issue_cnt != '1)) issue_cnt <= issue_cnt + COUNT_W'(1);
      case (state)
        S_IDLE, S_DONE: begin
          if (start && !stop) begin
            state     <= S_FETCH;
            pc        <= '0;
            loop_q    <= loop_en;
            last_q    <= last_addr;
            issue_cnt <= '0;
            done      <= 1'b0;
          end
        end
        S_FETCH: begin
          if (stop) begin
            state <= S_IDLE;
          end else begin
            state    <= S_ISSUE;
            instr    <= prog_mem[pc];
            instr_pc <= pc;
          end
        end
        default: begin
          if (stop) begin
            state <= S_IDLE;
          end else if (hs) begin
            if (at_last && !loop_q) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              // Read the next word on the handshake edge to keep one issue per cycle.
              pc       <= pc_nxt;
              instr    <= prog_mem[pc_nxt];
              instr_pc <= pc_nxt;
            end
          end
        end
      endcase
    end
  end

`ifdef MINIMIPS_RESULT_CAPTURE_EN
  logic [RESULT_W-1:0] cap_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (res_valid) cap_mem[res_pc] <= res_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) dbg_data <= '0;
    else        dbg_data <= cap_mem[dbg_addr];
  end
`else
  logic unused_capture;
  assign unused_capture = ^{res_valid, res_pc, res_data, dbg_addr};
  assign dbg_data       = '0;
`endif

endmodule

// File: tb/tb_minimips_instr_sequencer.sv
// Self-checking bench for minimips_instr_sequencer: vector table of runs plus directed
// stop/prog_err/reset/capture sequences; issued words are checked against a scoreboard queue.
module tb_minimips_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        prog_we;
  logic [5:0]  prog_addr;
  logic [15:0] prog_data;
  logic        start, stop, loop_en;
  logic [5:0]  last_addr;
  logic        instr_valid, instr_ready;
  logic [15:0] instr;
  logic [5:0]  instr_pc;
  logic        busy, done, prog_err;
  logic [15:0] issue_cnt;
  logic        res_valid;
  logic [5:0]  res_pc;
  logic [31:0] res_data;
  logic [5:0]  dbg_addr;
  logic [31:0] dbg_data;

  minimips_instr_sequencer #(.INSTR_W(16), .PC_W(6), .RESULT_W(32), .COUNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .start(start), .stop(stop), .loop_en(loop_en), .last_addr(last_addr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .busy(busy), .done(done), .prog_err(prog_err), .issue_cnt(issue_cnt),
    .res_valid(res_valid), .res_pc(res_pc), .res_data(res_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  pc;
    logic [15:0] w;
  } sb_t;

  typedef struct {
    logic       loop;
    logic [5:0] last;
    int         mode;     // 0: ready high, 1: ready toggles, 2: ready random
    int         exp_cnt;
    logic       exp_done;
  } vec_t;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] model [64];
  sb_t         sb [$];
  vec_t        vecs [5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Issue monitor: every handshake pops the scoreboard; stalled words must hold still.
  logic        hold_prev = 1'b0;
  logic [5:0]  hold_pc;
  logic [15:0] hold_w;
  always @(negedge clk) begin
    if (rst_n && hold_prev && instr_valid) begin
      chk("hold_pc", 64'(instr_pc), 64'(hold_pc));
      chk("hold_instr", 64'(instr), 64'(hold_w));
    end
    hold_prev = rst_n && instr_valid && !instr_ready;
    hold_pc   = instr_pc;
    hold_w    = instr;
    if (rst_n && instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'(instr_pc), 64'hFFFF);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("issue_pc", 64'(instr_pc), 64'(e.pc));
        chk("issue_instr", 64'(instr), 64'(e.w));
      end
    end
  end

  task automatic load(input logic [5:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(posedge clk); #1;
    prog_we = 1'b0;
    model[a] = d;
  endtask

  task automatic push_seq(input logic [5:0] last, input int n);
    int p = 0;
    for (int i = 0; i < n; i++) begin
      sb.push_back('{pc: 6'(p), w: model[p]});
      p = (p == int'(last)) ? 0 : p + 1;
    end
  endtask

  // Pulses start and checks the 2-cycle start->valid latency; leaves time at posedge+1.
  task automatic start_run(input logic lp, input logic [5:0] last);
    loop_en = lp; last_addr = last; instr_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("fetch_busy", 64'(busy), 64'd1);
    chk("fetch_valid", 64'(instr_valid), 64'd0);
    @(posedge clk); #1;
    chk("issue_valid", 64'(instr_valid), 64'd1);
  endtask

  task automatic run_row(input vec_t v, input int idx);
    int cyc = 0;
    push_seq(v.last, v.exp_cnt);
    start_run(v.loop, v.last);
    while (!done && cyc < 400) begin
      case (v.mode)
        0:       instr_ready = 1'b1;
        1:       instr_ready = cyc[0] ? 1'b0 : 1'b1;
        default: instr_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk); #1;
      cyc++;
    end
    instr_ready = 1'b0;
    chk($sformatf("row%0d_done", idx), 64'(done), 64'(v.exp_done));
    chk($sformatf("row%0d_cnt", idx), 64'(issue_cnt), 64'(v.exp_cnt));
    chk($sformatf("row%0d_busy", idx), 64'(busy), 64'd0);
    chk($sformatf("row%0d_valid", idx), 64'(instr_valid), 64'd0);
    chk($sformatf("row%0d_sb_left", idx), 64'(sb.size()), 64'd0);
  endtask

  initial begin
    vecs[0] = '{loop: 1'b0, last: 6'd3,  mode: 0, exp_cnt: 4,  exp_done: 1'b1};
    vecs[1] = '{loop: 1'b0, last: 6'd3,  mode: 1, exp_cnt: 4,  exp_done: 1'b1};
    vecs[2] = '{loop: 1'b0, last: 6'd0,  mode: 0, exp_cnt: 1,  exp_done: 1'b1};
    vecs[3] = '{loop: 1'b0, last: 6'd5,  mode: 2, exp_cnt: 6,  exp_done: 1'b1};
    vecs[4] = '{loop: 1'b0, last: 6'd63, mode: 0, exp_cnt: 64, exp_done: 1'b1};

    rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0; last_addr = '0; instr_ready = 1'b0;
    res_valid = 1'b0; res_pc = '0; res_data = '0; dbg_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_prog_err", 64'(prog_err), 64'd0);
    chk("rst_cnt", 64'(issue_cnt), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_pc", 64'(instr_pc), 64'd0);
    chk("rst_dbg", 64'(dbg_data), 64'd0);
    rst_n = 1'b1;

    for (int a = 4; a < 64; a++) load(6'(a), 16'($urandom));
    load(6'd0, 16'h0050);
    load(6'd1, 16'h07C0);
    load(6'd2, 16'h0EE1);
    load(6'd3, 16'h00C1);

    for (int i = 0; i < 5; i++) run_row(vecs[i], i);

    // Loop mode with stop; the handshake in the stop cycle still counts.
    push_seq(6'd1, 6);
    start_run(1'b1, 6'd1);
    for (int i = 0; i < 5; i++) begin
      instr_ready = 1'b1;
      @(posedge clk); #1;
    end
    chk("loop_done", 64'(done), 64'd0);
    chk("loop_cnt5", 64'(issue_cnt), 64'd5);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0; instr_ready = 1'b0;
    chk("stop_valid", 64'(instr_valid), 64'd0);
    chk("stop_busy", 64'(busy), 64'd0);
    chk("stop_done", 64'(done), 64'd0);
    chk("stop_cnt", 64'(issue_cnt), 64'd6);
    chk("stop_sb_left", 64'(sb.size()), 64'd0);

    // Stop wins over start in the same cycle.
    start = 1'b1; stop = 1'b1; loop_en = 1'b0; last_addr = 6'd3;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    chk("stop_wins_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("stop_wins_valid", 64'(instr_valid), 64'd0);

    // Write and start during a stalled run are rejected.
    start_run(1'b0, 6'd3);
    prog_we = 1'b1; prog_addr = 6'd1; prog_data = ~model[1]; start = 1'b1;
    @(posedge clk); #1;
    prog_we = 1'b0; start = 1'b0;
    chk("prog_err_pulse", 64'(prog_err), 64'd1);
    chk("busy_start_pc", 64'(instr_pc), 64'd0);
    chk("busy_start_valid", 64'(instr_valid), 64'd1);
    @(posedge clk); #1;
    chk("prog_err_clear", 64'(prog_err), 64'd0);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    run_row(vecs[0], 10);

    // Reset mid-issue clears outputs; store survives.
    push_seq(6'd3, 2);
    start_run(1'b0, 6'd3);
    for (int i = 0; i < 2; i++) begin
      instr_ready = 1'b1;
      @(posedge clk); #1;
    end
    chk("pre_rst_cnt", 64'(issue_cnt), 64'd2);
    instr_ready = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_valid", 64'(instr_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_cnt", 64'(issue_cnt), 64'd0);
    chk("mid_rst_instr", 64'(instr), 64'd0);
    chk("mid_rst_pc", 64'(instr_pc), 64'd0);
    chk("mid_rst_dbg", 64'(dbg_data), 64'd0);
    chk("mid_rst_sb_left", 64'(sb.size()), 64'd0);
    rst_n = 1'b1;
    run_row(vecs[0], 11);

    // Result capture: last write wins, 1-cycle read latency.
    res_valid = 1'b1; res_pc = 6'd2; res_data = 32'h1234_5678; dbg_addr = 6'd2;
    @(posedge clk); #1;
    res_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    res_valid = 1'b0;
    @(posedge clk); #1;
`ifdef MINIMIPS_RESULT_CAPTURE_EN
    chk("capture_dbg", 64'(dbg_data), 64'hDEAD_BEEF);
`else
    chk("capture_dbg", 64'(dbg_data), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
